// File: rtl/npu_dma_req_responder.sv
// Host-side DMA request responder: in-order queue plus a latency/beat timing FSM.
// Optional DMA_RESP_STALL_EN adds resp_stall to freeze timing and defer completion.
module npu_dma_req_responder #(
  parameter int FIFO_DEPTH = 4,
  parameter int BEAT_BYTES = 32,
  parameter int FIXED_LAT  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dma_req_valid,
  input  logic [63:0] dma_req_src,
  input  logic [63:0] dma_req_dst,
  input  logic [31:0] dma_req_bytes,
`ifdef DMA_RESP_STALL_EN
  input  logic        resp_stall,
`endif
  output logic        dma_req_ready,
  output logic        dma_resp_done,
  output logic        busy,
  output logic [31:0] req_count,
  output logic [31:0] done_count,
  output logic [63:0] cur_src,
  output logic [63:0] cur_dst
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int SH = $clog2(BEAT_BYTES);

  typedef enum logic [1:0] {
    IDLE,
    LAT,
    XFER,
    DONE
  } state_e;

  logic [63:0] src_mem [FIFO_DEPTH];
  logic [63:0] dst_mem [FIFO_DEPTH];
  logic [31:0] len_mem [FIFO_DEPTH];

  state_e        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   lat_q, lat_d;
  logic [32:0]   beats_q, beats_d;
  logic [63:0]   cur_src_q, cur_src_d;
  logic [63:0]   cur_dst_q, cur_dst_d;
  logic [31:0]   req_cnt_q, done_cnt_q, done_cnt_d;

  logic        stall;
  logic        push, pop, done;
  logic [32:0] beat_sum, beats_new;

`ifdef DMA_RESP_STALL_EN
  assign stall = resp_stall;
`else
  assign stall = 1'b0;
`endif

  assign dma_req_ready = !rst && (count_q != CW'(FIFO_DEPTH));
  assign push = dma_req_valid && dma_req_ready;
  assign pop  = (state_q == IDLE) && (count_q != '0);

  // 33-bit sum so a 0xFFFF_FFFF length rounds up without wrapping
  assign beat_sum  = {1'b0, len_mem[rd_ptr_q]} + 33'(BEAT_BYTES - 1);
  assign beats_new = beat_sum >> SH;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    lat_d      = lat_q;
    beats_d    = beats_q;
    cur_src_d  = cur_src_q;
    cur_dst_d  = cur_dst_q;
    done_cnt_d = done_cnt_q;
    done       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pop) begin
          cur_src_d = src_mem[rd_ptr_q];
          cur_dst_d = dst_mem[rd_ptr_q];
          beats_d   = beats_new;
          lat_d     = 32'(FIXED_LAT);
          if (FIXED_LAT > 0)
            state_d = LAT;
          else if (beats_new != '0)
            state_d = XFER;
          else
            state_d = DONE;
        end
      end
      LAT: begin
        if (!stall) begin
          lat_d = lat_q - 32'd1;
          if (lat_q == 32'd1)
            state_d = (beats_q != '0) ? XFER : DONE;
        end
      end
      XFER: begin
        if (!stall) begin
          beats_d = beats_q - 33'd1;
          if (beats_q == 33'd1)
            state_d = DONE;
        end
      end
      DONE: begin
        if (!stall) begin
          done       = !rst;
          done_cnt_d = done_cnt_q + 32'd1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      src_mem[wr_ptr_q] <= dma_req_src;
      dst_mem[wr_ptr_q] <= dma_req_dst;
      len_mem[wr_ptr_q] <= dma_req_bytes;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      lat_q      <= '0;
      beats_q    <= '0;
      cur_src_q  <= '0;
      cur_dst_q  <= '0;
      req_cnt_q  <= '0;
      done_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      lat_q      <= lat_d;
      beats_q    <= beats_d;
      cur_src_q  <= cur_src_d;
      cur_dst_q  <= cur_dst_d;
      done_cnt_q <= done_cnt_d;
      if (push) begin
        wr_ptr_q  <= wr_ptr_q + AW'(1);
        req_cnt_q <= req_cnt_q + 32'd1;
      end
      if (pop)
        rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  assign dma_resp_done = done;
  assign busy          = (state_q != IDLE) || (count_q != '0);
  assign req_count     = req_cnt_q;
  assign done_count    = done_cnt_q;
  assign cur_src       = cur_src_q;
  assign cur_dst       = cur_dst_q;

endmodule
